// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: ALU codes, mop fields
// and FSM state encodings.
package mdu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] MOP_MUL        = 2'b00;
    localparam logic [1:0] MOP_DIV        = 2'b01;
    localparam int         MOP_SIGNED_BIT = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MUL   = 3'd1;
    localparam logic [2:0] ST_DIV   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FIXUP = 3'd4;

endpackage

// File: rtl/mdu_seq.sv
// Iterative shift-add multiply / restoring divide that borrows the EX-stage ALU while busy.
// Optional signed support via `define MDU_SIGNED_EN (adds a FIXUP negation cycle).
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 5
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [1:0]   mop,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    input  logic [W-1:0] ex_alua,
    input  logic [W-1:0] ex_alub,
    input  logic [2:0]   ex_ealuc,
    output logic [W-1:0] alua,
    output logic [W-1:0] alub,
    output logic [2:0]   ealuc,
    input  logic [W-1:0] ealu
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     acc_q, low_q, opd_q;
    logic [W-1:0]     hi_q, lo_q;
    logic             dz_q;

    logic             accept;
    logic             div_zero;
    logic [W-1:0]     mag_a, mag_b;
    logic [W-1:0]     shift_s;
    logic [W-1:0]     iter_acc, iter_low;
    logic             carry;

`ifdef MDU_SIGNED_EN
    logic sgn_op;
    logic signed_q, div_q, neg_lo_q, neg_hi_q;

    assign sgn_op = mop[MOP_SIGNED_BIT];
    assign mag_a  = (sgn_op && opa[W-1]) ? -opa : opa;
    assign mag_b  = (sgn_op && opb[W-1]) ? -opb : opb;
`else
    logic unused_sgn;

    assign unused_sgn = mop[MOP_SIGNED_BIT];
    assign mag_a      = opa;
    assign mag_b      = opb;
`endif

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign div_zero = mop[0] && (opb == '0);
    assign shift_s  = {acc_q[W-2:0], low_q[W-1]};

    // ALU is shared: pass EX operands through unless an iteration owns it.
    always_comb begin
        alua     = ex_alua;
        alub     = ex_alub;
        ealuc    = ex_ealuc;
        iter_acc = acc_q;
        iter_low = low_q;
        carry    = 1'b0;
        case (state_q)
            ST_MUL: begin
                alua     = acc_q;
                alub     = low_q[0] ? opd_q : '0;
                ealuc    = ALU_ADD;
                carry    = (ealu < acc_q);
                iter_acc = {carry, ealu[W-1:1]};
                iter_low = {ealu[0], low_q[W-1:1]};
            end
            ST_DIV: begin
                alua  = shift_s;
                alub  = opd_q;
                ealuc = ALU_SUB;
                // R[31] set means the shifted remainder exceeds 32 bits, so it always fits D.
                if (acc_q[W-1] || shift_s >= opd_q) begin
                    iter_acc = ealu;
                    iter_low = {low_q[W-2:0], 1'b1};
                end else begin
                    iter_acc = shift_s;
                    iter_low = {low_q[W-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!start)        state_d = ST_IDLE;
                else if (div_zero) state_d = ST_DONE;
                else               state_d = mop[0] ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
`ifdef MDU_SIGNED_EN
                    state_d = signed_q ? ST_FIXUP : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            ST_FIXUP: state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            acc_q <= '0;
            low_q <= '0;
            opd_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '1;
            acc_q <= '0;
            low_q <= mop[0] ? mag_a : mag_b;
            opd_q <= mop[0] ? mag_b : mag_a;
            if (div_zero) begin
                dz_q <= 1'b1;
                hi_q <= opa;
                lo_q <= '1;
            end
        end else if (state_q == ST_MUL || state_q == ST_DIV) begin
            acc_q <= iter_acc;
            low_q <= iter_low;
            cnt_q <= cnt_q - CNT_W'(1);
`ifdef MDU_SIGNED_EN
            if (cnt_q == '0 && !signed_q) begin
`else
            if (cnt_q == '0) begin
`endif
                hi_q <= iter_acc;
                lo_q <= iter_low;
                dz_q <= 1'b0;
            end
        end
`ifdef MDU_SIGNED_EN
        else if (state_q == ST_FIXUP) begin
            dz_q <= 1'b0;
            if (!div_q) begin
                {hi_q, lo_q} <= neg_lo_q ? -{acc_q, low_q} : {acc_q, low_q};
            end else begin
                lo_q <= neg_lo_q ? -low_q : low_q;
                hi_q <= neg_hi_q ? -acc_q : acc_q;
            end
        end
`endif
    end

`ifdef MDU_SIGNED_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (accept) begin
            signed_q <= sgn_op;
            div_q    <= mop[0];
            neg_lo_q <= sgn_op && (opa[W-1] ^ opb[W-1]);
            neg_hi_q <= sgn_op && (mop[0] ? opa[W-1] : (opa[W-1] ^ opb[W-1]));
        end
    end
`endif

    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIXUP);
    assign done = (state_q == ST_DONE);
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected results, ALU modelled here.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mop = 2'b00;
    logic [31:0] opa = '0, opb = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    logic [31:0] ex_alua = '0, ex_alub = '0;
    logic [2:0]  ex_ealuc = '0;
    logic [31:0] alua, alub, ealu;
    logic [2:0]  ealuc;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    mdu_seq #(.W(32), .CNT_W(5)) dut (
        .clock(clock), .resetn(resetn), .start(start), .mop(mop), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo),
        .ex_alua(ex_alua), .ex_alub(ex_alub), .ex_ealuc(ex_ealuc),
        .alua(alua), .alub(alub), .ealuc(ealuc), .ealu(ealu)
    );

    always #5 clock = ~clock;

    always_comb ealu = (ealuc == ALU_SUB) ? (alua - alub) : (alua + alub);

    function automatic exp_t model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv;
        bit          sgn;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = m[1];
`endif
        e.dz = 1'b0;
        e.lat = 0;
        if (!m[0]) begin
            if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else     p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'b0) begin
            e.dz = 1'b1;
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Called at a negedge: drives the request and records its expected outcome.
    task automatic launch(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        exp_t e;
        e = model(m, a, b);
        e.lat = lat;
        sb.push_back(e);
        start = 1'b1;
        mop   = m;
        opa   = a;
        opb   = b;
    endtask

    task automatic finish_op(input int ignore_at, input bit chain, input logic [1:0] m2,
                             input logic [31:0] a2, input logic [31:0] b2, input int lat2);
        int   k = 0;
        int   nbusy = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && k < 40) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) seen = 1'b1;
            else if (k == ignore_at) begin
                start = 1'b1;
                mop   = MOP_DIV;
                opa   = 32'h9;
                opb   = 32'h2;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen || k != e.lat) $display("FAIL latency: got %0d (seen=%0d) want %0d", k, seen, e.lat);
        else n_pass++;
        n_checks++;
        if (nbusy != e.lat - 1) $display("FAIL busy_cycles: got %0d want %0d", nbusy, e.lat - 1);
        else n_pass++;
        n_checks++;
        if (hi !== e.hi) $display("FAIL hi: got %h want %h", hi, e.hi);
        else n_pass++;
        n_checks++;
        if (lo !== e.lo) $display("FAIL lo: got %h want %h", lo, e.lo);
        else n_pass++;
        n_checks++;
        if (dz !== e.dz) $display("FAIL dz: got %b want %b", dz, e.dz);
        else n_pass++;
        if (chain) launch(m2, a2, b2, lat2);
        else begin
            @(negedge clock);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_after_done: got done=%b busy=%b want 0 0", done, busy);
            else n_pass++;
        end
    endtask

    task automatic one_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        @(negedge clock);
        launch(m, a, b, lat);
        finish_op(0, 1'b0, 2'b00, 32'b0, 32'b0, 0);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, dz} !== 3'b000 || hi !== 32'b0 || lo !== 32'b0)
            $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, dz, hi, lo);
        else n_pass++;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_passthrough();
        @(negedge clock);
        ex_alua = 32'd5;
        ex_alub = 32'd3;
        ex_ealuc = 3'b110;
        #1;
        n_checks++;
        if (alua !== 32'd5 || alub !== 32'd3 || ealuc !== 3'b110 || busy !== 1'b0)
            $display("FAIL passthrough: got %h %h %b busy=%b want 5 3 110 0",
                     alua, alub, ealuc, busy);
        else n_pass++;
    endtask

    task automatic test_mul();
        one_op(MOP_MUL, 32'd3, 32'd5, 33);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd15) $display("FAIL mul_3x5: got %h_%h want 0_f", hi, lo);
        else n_pass++;
        one_op(MOP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h1)
            $display("FAIL mul_max: got %h_%h want fffffffe_00000001", hi, lo);
        else n_pass++;
        one_op(MOP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 33);
        one_op(MOP_MUL, 32'h0, 32'h8000_0001, 33);
        one_op(MOP_MUL, $urandom, $urandom, 33);
    endtask

    task automatic test_div();
        one_op(MOP_DIV, 32'd100, 32'd7, 33);
        n_checks++;
        if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_100_7: got q=%0d r=%0d want 14 2", lo, hi);
        else n_pass++;
        one_op(MOP_DIV, 32'hFFFF_FFFF, 32'd1, 33);
        one_op(MOP_DIV, 32'd7, 32'd100, 33);
        one_op(MOP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 33);
        one_op(MOP_DIV, $urandom, $urandom_range(1, 65535), 33);
    endtask

    task automatic test_divzero();
        one_op(MOP_DIV, 32'h1234, 32'h0, 1);
        n_checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234) $display("FAIL divzero: got %h_%h want 1234_ffffffff", hi, lo);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        @(negedge clock);
        launch(MOP_MUL, 32'd3, 32'd5, 33);
        finish_op(10, 1'b0, 2'b00, 32'b0, 32'b0, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        launch(MOP_DIV, 32'd1000, 32'd33, 33);
        finish_op(0, 1'b1, MOP_MUL, 32'h0001_0001, 32'h0001_0001, 33);
        finish_op(0, 1'b0, 2'b00, 32'b0, 32'b0, 0);
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        @(negedge clock);
        start = 1'b1;
        mop   = MOP_MUL;
        opa   = 32'd7;
        opb   = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'b0 || lo !== 32'b0)
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
        else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) $display("FAIL no_done_after_abort: got %0d pulses want 0", ndone);
        else n_pass++;
    endtask

`ifdef MDU_SIGNED_EN
    task automatic test_signed();
        one_op(2'b10, 32'hFFFF_FFFA, 32'd7, 34);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6)
            $display("FAIL smul_m6x7: got %h_%h want ffffffff_ffffffd6", hi, lo);
        else n_pass++;
        one_op(2'b11, 32'hFFFF_FFF9, 32'd2, 34);
        n_checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
            $display("FAIL sdiv_m7_2: got q=%h r=%h want fffffffd ffffffff", lo, hi);
        else n_pass++;
        one_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        one_op(2'b11, 32'hFFFF_FF00, 32'h0, 1);
        one_op(2'b10, $urandom, $urandom, 34);
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_mul();
        test_div();
        test_divzero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`ifdef MDU_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that time-shares the pipeline's single 32-bit combinational ALU.
- Idle: EX-stage operands and ALU control pass straight through to the ALU.
- Busy: the block takes over the ALU. Multiply uses shift-add with ALU add (code 000). Restoring divide uses ALU subtract (code 110).
- Sits beside the EX stage. `busy` drives the pipeline stall.

Parameters:
- W, 32, datapath width; must equal ALU width (32).
- CNT_W, 5, iteration counter width, log2(W).

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled in IDLE or DONE
- mop  in  2  bit0: 0=mul, 1=div; bit1: signed (see optional feature)
- opa  in  32  multiplicand / dividend
- opb  in  32  multiplier / divisor
- busy  out  1  high while iterating; pipeline stall
- done  out  1  one-cycle completion pulse
- dz  out  1  divide-by-zero flag, valid with done
- hi  out  32  mul: product[63:32]; div: remainder
- lo  out  32  mul: product[31:0]; div: quotient
- ex_alua, ex_alub  in  32  EX-stage ALU operands
- ex_ealuc  in  3  EX-stage ALU control
- alua, alub  out  32  to ALU
- ealuc  out  3  to ALU
- ealu  in  32  ALU result

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy=0, done=0, dz=0, hi=0, lo=0; counter=0.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, MUL, DIV, DONE (plus FIXUP when MDU_SIGNED_EN is defined).
- ALU mux: in IDLE/DONE, alua/alub/ealuc = ex_* (combinational). In MUL/DIV, driven by the sequencer.
- start=1 at edge N (state IDLE or DONE):
  - Latch operands and mop.
  - Go to MUL or DIV with counter=31.
  - Exception: div with opb=0 goes directly to DONE with dz=1, lo=32'hFFFFFFFF, hi=opa.
- start is ignored while busy.
- MUL, registers P_hi=0, P_lo=opb, M=opa, per cycle:
  - alua=P_hi; alub = P_lo[0] ? M : 0; ealuc=000.
  - c = (ealu < P_hi).
  - {P_hi,P_lo} <= {c, ealu, P_lo} >> 1.
- DIV, registers R=0, Q=opa, D=opb, per cycle:
  - s = {R[30:0], Q[31]}; t = R[31].
  - alua=s; alub=D; ealuc=110.
  - If t or s>=D: R<=ealu, Q<={Q[30:0],1}. Otherwise R<=s, Q<={Q[30:0],0}.
- Counter decrements each iteration. At counter==0 go to DONE; the results are written into hi/lo on that edge.
- Latency: busy=1 for cycles N+1..N+32. DONE at N+33 with done=1.
- hi/lo hold until the next accepted start completes or reset.
- DONE returns to IDLE unless start=1, in which case a new operation begins.
- All arithmetic is unsigned mod 2^32 per ALU pass; the carry/borrow is computed locally, not by the ALU.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - mop[1]=1 selects signed.
  - Operands are converted to magnitudes at start.
  - Result signs: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - An extra FIXUP cycle applies two's-complement negation (64-bit for product).
  - busy stays high through FIXUP; done arrives at N+34.
  - Div 0x80000000 / -1 yields lo=0x80000000, hi=0.
  - Divide-by-zero result is unchanged from the unsigned case.
- Undefined: mop[1] is ignored, all operations are unsigned, and the FIXUP state does not exist.

Decomposition:
- Shared package (mdu_pkg) holds:
  - ALU code constants ALU_ADD=3'b000, ALU_SUB=3'b110.
  - mop encodings MOP_MUL, MOP_DIV, MOP_SIGNED_BIT.
  - State encoding constants.
- No sub-module. A single FSM/datapath module; the ALU itself stays external and shared.

Test Plan:
- Idle pass-through: ex_alua=5, ex_alub=3, ex_ealuc=110 -> alua=5, alub=3, ealuc=110 same cycle; busy=0.
- MUL 3*5: start at N -> busy N+1..N+32; done at N+33; hi=0, lo=15. Also FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 -> lo=14, hi=2, dz=0. Also 0xFFFFFFFF/1 -> lo=FFFFFFFF, hi=0.
- Divide by zero: opa=0x1234, opb=0 -> done at N+1, dz=1, lo=FFFFFFFF, hi=0x1234, busy never asserted.
- start pulsed at N+10 during MUL is ignored (result unchanged). resetn low at N+15 -> busy=0, hi=lo=0, no done. Back-to-back start during DONE is accepted.
- With MDU_SIGNED_EN: -6*7 -> hi=FFFFFFFF, lo=FFFFFFD6, done at N+34; -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
